rpn_sequencer: RTL and testbench

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

---
 rtl/rpn_sequencer_pkg.sv | 67 ++++++
 rtl/rpn_sequencer_depth_chk.sv | 72 +++++++
 rtl/rpn_sequencer.sv | 175 +++++++++++++++++
 tb/tb_rpn_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rpn_sequencer_pkg
//   Shared definitions for the RPN sequencer and the opstack ALU:
//   token kind codes, error codes, ALU opcodes and the sequencer FSM states.
//   No ports (package).
// ---------------------------------------------------------------------------
package rpn_sequencer_pkg;

    // Token kinds as presented on tok_kind
    typedef enum logic [1:0] {
        TK_NUM = 2'b00,
        TK_OP  = 2'b01,
        TK_END = 2'b10,
        TK_ILL = 2'b11
    } tok_kind_e;

    // Error codes reported on err_code
    typedef enum logic [2:0] {
        ERR_NONE       = 3'b000,
        ERR_UNDERFLOW  = 3'b001,
        ERR_OVERFLOW   = 3'b010,
        ERR_BAD_END    = 3'b011,
        ERR_BAD_OPCODE = 3'b100,
        ERR_BAD_TOKEN  = 3'b101
    } err_code_e;

    // ALU opcodes: 0..15 are binary (pop two, push one), 16..18 are unary
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8;
    localparam logic [4:0] OP_MIN  = 5'd9;
    localparam logic [4:0] OP_MAX  = 5'd10;
    localparam logic [4:0] OP_EQ   = 5'd11;
    localparam logic [4:0] OP_NE   = 5'd12;
    localparam logic [4:0] OP_GT   = 5'd13;
    localparam logic [4:0] OP_GE   = 5'd14;
    localparam logic [4:0] OP_LT   = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_BNOT = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_EXEC,
        S_CAPT,
        S_DONE,
        S_ERR
    } seq_state_e;

    function automatic logic is_binary_op(input logic [4:0] opc);
        return (opc <= OP_LT);
    endfunction

    function automatic logic is_unary_op(input logic [4:0] opc);
        return (opc >= OP_NEG) && (opc <= OP_NOT);
    endfunction

endpackage

// File: rtl/rpn_sequencer_depth_chk.sv
// ---------------------------------------------------------------------------
// rpn_depth_chk
//   Combinational legality check and depth bookkeeping for one token.
//   Ports:
//     kind       in   token kind (tok_kind_e encoding)
//     opcode     in   operator opcode (only meaningful for operator tokens)
//     depth      in   current tracked opstack occupancy
//     legal      out  1 when the token may be executed
//     err_code   out  error code when legal=0, ERR_NONE otherwise
//     next_depth out  occupancy after the token executes (depth when illegal)
// ---------------------------------------------------------------------------
module rpn_depth_chk
    import rpn_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [1:0]                   kind,
    input  logic [4:0]                   opcode,
    input  logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         legal,
    output logic [2:0]                   err_code,
    output logic [$clog2(DEPTH+1)-1:0]   next_depth
);

    localparam int DW = $clog2(DEPTH+1);

    always_comb begin
        legal      = 1'b1;
        err_code   = ERR_NONE;
        next_depth = depth;
        case (tok_kind_e'(kind))
            TK_NUM: begin
                if (depth == DW'(DEPTH)) begin
                    legal    = 1'b0;
                    err_code = ERR_OVERFLOW;
                end else begin
                    next_depth = depth + DW'(1);
                end
            end
            TK_OP: begin
                if (is_binary_op(opcode)) begin
                    if (depth < DW'(2)) begin
                        legal    = 1'b0;
                        err_code = ERR_UNDERFLOW;
                    end else begin
                        next_depth = depth - DW'(1);
                    end
                end else if (is_unary_op(opcode)) begin
                    // Unary ops replace the top entry: occupancy unchanged
                    if (depth == '0) begin
                        legal    = 1'b0;
                        err_code = ERR_UNDERFLOW;
                    end
                end else begin
                    legal    = 1'b0;
                    err_code = ERR_BAD_OPCODE;
                end
            end
            TK_END: begin
                if (depth != DW'(1)) begin
                    legal    = 1'b0;
                    err_code = ERR_BAD_END;
                end
            end
            default: begin
                legal    = 1'b0;
                err_code = ERR_BAD_TOKEN;
            end
        endcase
    end

endmodule

// File: rtl/rpn_sequencer.sv
// ---------------------------------------------------------------------------
// rpn_sequencer
//   Feeds a token stream (numbers, operators, end) into an external opstack,
//   tracking stack depth so that underflow/overflow and malformed programs
//   are caught before any strobe reaches the opstack.
//   Ports:
//     clk, rst_n         clock (rising edge), asynchronous active-low reset
//     start              begin a program (honoured in IDLE, DONE, ERR only)
//     tok_valid/ready    token handshake; ready is decoded from state
//     tok_kind, tok_data token kind and value/opcode
//     num, op, x         opstack push / operate strobes and data/opcode
//     clr_n              registered active-low opstack clear
//     qtop               opstack top of stack
//     result             value captured at the end token
//     busy, done, err    status flags; err_code gives the error reason
//     depth              tracked opstack occupancy
// ---------------------------------------------------------------------------
module rpn_sequencer
    import rpn_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         tok_valid,
    output logic                         tok_ready,
    input  logic [1:0]                   tok_kind,
    input  logic [15:0]                  tok_data,
    output logic                         num,
    output logic                         op,
    output logic [15:0]                  x,
    output logic                         clr_n,
    input  logic [15:0]                  qtop,
    output logic [15:0]                  result,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [2:0]                   err_code,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int DW = $clog2(DEPTH+1);

    seq_state_e     state_q, state_d;
    logic           num_q, num_d;
    logic           op_q, op_d;
    logic [15:0]    x_q, x_d;
    logic           clr_n_q, clr_n_d;
    logic [15:0]    result_q, result_d;
    logic [DW-1:0]  depth_q, depth_d;
    logic [2:0]     err_code_q, err_code_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           chk_legal;
    logic [2:0]     chk_err_code;
    logic [DW-1:0]  chk_next_depth;

    rpn_depth_chk #(
        .DEPTH (DEPTH)
    ) u_depth_chk (
        .kind       (tok_kind),
        .opcode     (tok_data[4:0]),
        .depth      (depth_q),
        .legal      (chk_legal),
        .err_code   (chk_err_code),
        .next_depth (chk_next_depth)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            num_q      <= 1'b0;
            op_q       <= 1'b0;
            x_q        <= '0;
            clr_n_q    <= 1'b1;
            result_q   <= '0;
            depth_q    <= '0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            op_q       <= op_d;
            x_q        <= x_d;
            clr_n_q    <= clr_n_d;
            result_q   <= result_d;
            depth_q    <= depth_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Every registered output is computed from the *next* state, so the
    // strobes and flags line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        num_d      = 1'b0;
        op_d       = 1'b0;
        x_d        = '0;
        clr_n_d    = 1'b1;
        depth_d    = depth_q;
        err_code_d = err_code_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    clr_n_d    = 1'b0;
                    depth_d    = '0;
                    err_code_d = ERR_NONE;
                end
            end
            S_CLEAR: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (tok_valid) begin
                    if (!chk_legal) begin
                        // Offending token never produces a strobe
                        state_d    = S_ERR;
                        err_code_d = chk_err_code;
                    end else if (tok_kind_e'(tok_kind) == TK_END) begin
                        state_d = S_CAPT;
                    end else begin
                        state_d = S_EXEC;
                        depth_d = chk_next_depth;
                        if (tok_kind_e'(tok_kind) == TK_NUM) begin
                            num_d = 1'b1;
                            x_d   = tok_data;
                        end else begin
                            op_d = 1'b1;
                            x_d  = {11'b0, tok_data[4:0]};
                        end
                    end
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
            end
            S_CAPT: begin
                // The last EXEC strobe has settled in the opstack by now
                state_d  = S_DONE;
                result_d = qtop;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d == S_CLEAR) || (state_d == S_FETCH) ||
                    (state_d == S_EXEC)  || (state_d == S_CAPT);
    assign done_d = (state_d == S_DONE);
    assign err_d  = (state_d == S_ERR);

    assign tok_ready = (state_q == S_FETCH);
    assign num       = num_q;
    assign op        = op_q;
    assign x         = x_q;
    assign clr_n     = clr_n_q;
    assign result    = result_q;
    assign depth     = depth_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
`timescale 1ns/1ps
module tb_rpn_sequencer;
    import rpn_sequencer_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          tok_valid = 1'b0;
    logic [1:0]    tok_kind = 2'b00;
    logic [15:0]   tok_data = 16'h0;
    logic          tok_ready, num, op, clr_n, busy, done, err;
    logic [15:0]   x, result;
    logic [15:0]   qtop = 16'h0;
    logic [2:0]    err_code;
    logic [DW-1:0] depth;

    always #5 clk = ~clk;

    rpn_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_kind(tok_kind), .tok_data(tok_data),
        .num(num), .op(op), .x(x), .clr_n(clr_n), .qtop(qtop),
        .result(result), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .depth(depth)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed { logic [1:0] kind; logic [15:0] data; } tok_t;
    typedef struct packed { logic is_op; logic [15:0] x; } ev_t;

    tok_t        prog[$];
    ev_t         exp_ev[$];
    logic [15:0] model_result = 16'h0;
    int          num_cnt = 0, op_cnt = 0, clr_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Reference opstack arithmetic (a = second entry, b = top)
    function automatic logic [15:0] alu2(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b);
        case (opc)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_MUL: return a * b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_SHL: return a << b[3:0];
            OP_SHR: return a >> b[3:0];
            OP_SRA: return $signed(a) >>> b[3:0];
            OP_MIN: return ($signed(a) < $signed(b)) ? a : b;
            OP_MAX: return ($signed(a) > $signed(b)) ? a : b;
            OP_EQ:  return {15'b0, a == b};
            OP_NE:  return {15'b0, a != b};
            OP_GT:  return {15'b0, $signed(a) > $signed(b)};
            OP_GE:  return {15'b0, $signed(a) >= $signed(b)};
            OP_LT:  return {15'b0, $signed(a) < $signed(b)};
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [15:0] alu1(input logic [4:0] opc, input logic [15:0] a);
        case (opc)
            OP_NEG:  return 16'h0 - a;
            OP_BNOT: return ~a;
            OP_NOT:  return {15'b0, a == 16'h0};
            default: return 16'h0;
        endcase
    endfunction

    // Opstack stand-in: reacts to the strobes, drives qtop
    initial begin
        logic [15:0] stk[$];
        logic [15:0] ea, eb;
        forever begin
            @(negedge clk);
            if (!rst_n || !clr_n) begin
                stk.delete();
            end else if (num) begin
                stk.push_back(x);
            end else if (op) begin
                if (x[4:0] <= 5'd15 && stk.size() >= 2) begin
                    eb = stk.pop_back();
                    ea = stk.pop_back();
                    stk.push_back(alu2(x[4:0], ea, eb));
                end else if (stk.size() >= 1) begin
                    ea = stk.pop_back();
                    stk.push_back(alu1(x[4:0], ea));
                end
            end
            qtop = (stk.size() > 0) ? stk[stk.size()-1] : 16'h0;
        end
    end

    // Per-cycle compare against the expected strobe stream and invariants
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!clr_n) clr_cnt++;
                if (num) num_cnt++;
                if (op)  op_cnt++;
                check("num_op_exclusive", {31'b0, num & op}, 32'd0);
                check("ready_implies_busy", {31'b0, tok_ready & ~busy}, 32'd0);
                if (num || op) begin
                    if (exp_ev.size() == 0) begin
                        check("strobe_unexpected", {31'b0, num | op}, 32'd0);
                    end else begin
                        ev = exp_ev.pop_front();
                        check("strobe_kind_is_op", {31'b0, op}, {31'b0, ev.is_op});
                        check("strobe_x", {16'b0, x}, {16'b0, ev.x});
                    end
                end else begin
                    check("x_idle_zero", {16'b0, x}, 32'd0);
                end
            end
        end
    end

    // Program-level model: walk the tokens with a stack, stop at the first
    // error or at a legal end token.
    task automatic model_prog(output int last, output logic [2:0] ecode, output int edepth, output logic edone);
        logic [15:0] s[$];
        logic [15:0] a, b;
        logic [4:0]  opc;
        ev_t         ev;
        ecode = 3'b000;
        edone = 1'b0;
        last  = prog.size() - 1;
        for (int i = 0; i < prog.size(); i++) begin
            opc = prog[i].data[4:0];
            case (prog[i].kind)
                2'b00: begin
                    if (s.size() == DEPTH) ecode = 3'b010;
                    else begin
                        s.push_back(prog[i].data);
                        ev.is_op = 1'b0; ev.x = prog[i].data; exp_ev.push_back(ev);
                    end
                end
                2'b01: begin
                    if (opc <= 5'd15) begin
                        if (s.size() < 2) ecode = 3'b001;
                        else begin
                            b = s.pop_back(); a = s.pop_back();
                            s.push_back(alu2(opc, a, b));
                            ev.is_op = 1'b1; ev.x = {11'b0, opc}; exp_ev.push_back(ev);
                        end
                    end else if (opc <= 5'd18) begin
                        if (s.size() < 1) ecode = 3'b001;
                        else begin
                            a = s.pop_back();
                            s.push_back(alu1(opc, a));
                            ev.is_op = 1'b1; ev.x = {11'b0, opc}; exp_ev.push_back(ev);
                        end
                    end else begin
                        ecode = 3'b100;
                    end
                end
                2'b10: begin
                    if (s.size() != 1) ecode = 3'b011;
                    else begin
                        edone = 1'b1;
                        model_result = s[0];
                    end
                end
                default: ecode = 3'b101;
            endcase
            if (ecode != 3'b000 || edone) begin
                last = i;
                break;
            end
        end
        edepth = s.size();
    endtask

    task automatic t_num(input logic [15:0] d); tok_t t; t.kind = 2'b00; t.data = d; prog.push_back(t); endtask
    task automatic t_op(input logic [4:0] c);   tok_t t; t.kind = 2'b01; t.data = {11'b0, c}; prog.push_back(t); endtask
    task automatic t_end();                      tok_t t; t.kind = 2'b10; t.data = 16'h0; prog.push_back(t); endtask
    task automatic t_ill();                      tok_t t; t.kind = 2'b11; t.data = 16'h1234; prog.push_back(t); endtask

    // Run the current program; in stall mode every token first sees one
    // FETCH cycle with tok_valid=0 (and a start pulse that must be ignored).
    task automatic run_prog(input string nm, input bit stall);
        int         last, edepth, clr0, cyc;
        logic [2:0] ecode;
        logic       edone;
        bit         acc, stalled;
        model_prog(last, ecode, edepth, edone);
        clr0 = clr_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i <= last; i++) begin
            tok_kind = prog[i].kind;
            tok_data = prog[i].data;
            acc = 1'b0; stalled = !stall; cyc = 0;
            while (!acc && cyc < 50) begin
                if (tok_ready) begin
                    if (!stalled) begin
                        tok_valid = 1'b0; start = 1'b1; stalled = 1'b1;
                    end else begin
                        tok_valid = 1'b1; start = 1'b0; acc = 1'b1;
                    end
                end else begin
                    tok_valid = !stall; start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            if (!acc) check({nm, ".accept_timeout"}, 32'd0, 32'd1);
        end
        tok_valid = 1'b0;
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 50) begin @(negedge clk); cyc++; end
        check({nm, ".finish_timeout"}, {31'b0, busy}, 32'd0);
        check({nm, ".done"}, {31'b0, done}, {31'b0, edone});
        check({nm, ".err"}, {31'b0, err}, {31'b0, ecode != 3'b000});
        check({nm, ".err_code"}, {29'b0, err_code}, {29'b0, ecode});
        check({nm, ".depth"}, 32'(depth), 32'(edepth));
        check({nm, ".result"}, {16'b0, result}, {16'b0, model_result});
        check({nm, ".strobes_left"}, 32'(exp_ev.size()), 32'd0);
        check({nm, ".clr_pulses"}, 32'(clr_cnt - clr0), 32'd1);
        $display("program %s: done=%0b err=%0b err_code=%0d depth=%0d result=%04h",
                 nm, done, err, err_code, depth, result);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".num"}, {31'b0, num}, 32'd0);
        check({nm, ".op"}, {31'b0, op}, 32'd0);
        check({nm, ".x"}, {16'b0, x}, 32'd0);
        check({nm, ".clr_n"}, {31'b0, clr_n}, 32'd1);
        check({nm, ".result"}, {16'b0, result}, 32'd0);
        check({nm, ".depth"}, 32'(depth), 32'd0);
        check({nm, ".busy"}, {31'b0, busy}, 32'd0);
        check({nm, ".done"}, {31'b0, done}, 32'd0);
        check({nm, ".err"}, {31'b0, err}, 32'd0);
        check({nm, ".err_code"}, {29'b0, err_code}, 32'd0);
        check({nm, ".tok_ready"}, {31'b0, tok_ready}, 32'd0);
    endtask

    initial begin
        int n0, o0, cyc;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 3 4 ADD end -> 7
        prog.delete(); t_num(16'd3); t_num(16'd4); t_op(OP_ADD); t_end();
        n0 = num_cnt; o0 = op_cnt;
        run_prog("add", 1'b0);
        check("add.lit_result", {16'b0, result}, 32'd7);
        check("add.lit_depth", 32'(depth), 32'd1);
        check("add.num_pulses", 32'(num_cnt - n0), 32'd2);
        check("add.op_pulses", 32'(op_cnt - o0), 32'd1);

        // 6 NEG end -> FFFA
        prog.delete(); t_num(16'd6); t_op(OP_NEG); t_end();
        o0 = op_cnt;
        run_prog("neg", 1'b0);
        check("neg.lit_result", {16'b0, result}, 32'h0000FFFA);
        check("neg.op_pulses", 32'(op_cnt - o0), 32'd1);

        // 5 ADD -> underflow, no op pulse, result kept from previous run
        prog.delete(); t_num(16'd5); t_op(OP_ADD);
        o0 = op_cnt;
        run_prog("underflow", 1'b0);
        check("underflow.lit_code", {29'b0, err_code}, 32'd1);
        check("underflow.lit_depth", 32'(depth), 32'd1);
        check("underflow.op_pulses", 32'(op_cnt - o0), 32'd0);

        // unary underflow on empty stack
        prog.delete(); t_op(OP_BNOT);
        run_prog("unary_underflow", 1'b0);

        // nine numbers -> eight pushes then overflow
        prog.delete();
        for (int i = 1; i <= 9; i++) t_num(16'(i));
        n0 = num_cnt;
        run_prog("overflow", 1'b0);
        check("overflow.num_pulses", 32'(num_cnt - n0), 32'd8);
        check("overflow.lit_code", {29'b0, err_code}, 32'd2);

        // full stack then seven ADDs -> 36
        prog.delete();
        for (int i = 1; i <= 8; i++) t_num(16'(i));
        for (int i = 0; i < 7; i++) t_op(OP_ADD);
        t_end();
        run_prog("full_stack", 1'b0);
        check("full_stack.lit_result", {16'b0, result}, 32'd36);

        prog.delete(); t_num(16'd1); t_num(16'd2); t_end();
        run_prog("bad_end", 1'b0);
        check("bad_end.lit_code", {29'b0, err_code}, 32'd3);

        prog.delete(); t_end();
        run_prog("empty_end", 1'b0);

        prog.delete(); t_num(16'd1); t_op(5'd25);
        run_prog("bad_opcode", 1'b0);
        check("bad_opcode.lit_code", {29'b0, err_code}, 32'd4);

        prog.delete(); t_num(16'd1); t_ill();
        run_prog("bad_token", 1'b0);
        check("bad_token.lit_code", {29'b0, err_code}, 32'd5);

        // (10-3)*2 then BNOT -> FFF1
        prog.delete(); t_num(16'd10); t_num(16'd3); t_op(OP_SUB); t_num(16'd2);
        t_op(OP_MUL); t_op(OP_BNOT); t_end();
        run_prog("mixed", 1'b0);
        check("mixed.lit_result", {16'b0, result}, 32'h0000FFF1);

        // stalled handshake, start pulsed while busy
        prog.delete(); t_num(16'd3); t_num(16'd4); t_op(OP_ADD); t_end();
        run_prog("add_stalled", 1'b1);
        check("add_stalled.lit_result", {16'b0, result}, 32'd7);

        // asynchronous reset while in EXEC
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        tok_kind = 2'b00; tok_data = 16'd3; tok_valid = 1'b1;
        cyc = 0;
        while (!tok_ready && cyc < 20) begin @(negedge clk); cyc++; end
        check("rst_exec.reach_fetch", {31'b0, tok_ready}, 32'd1);
        @(posedge clk); #1;
        check("rst_exec.in_exec", {31'b0, num}, 32'd1);
        rst_n = 1'b0;
        tok_valid = 1'b0;
        #1;
        check_reset_outputs("rst_exec");
        exp_ev.delete();
        model_result = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        prog.delete(); t_num(16'd3); t_num(16'd4); t_op(OP_ADD); t_end();
        run_prog("after_reset", 1'b0);
        check("after_reset.lit_result", {16'b0, result}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
